collision_scheduler: RTL
========================

# collision_scheduler

Sequences tile-map collision probes for both fighters once per frame. On each frame tick it walks eight probe points around each character's bounding box, issues one tile-ROM lookup per cycle over a shared address port, and folds the returned tile data into per-player left/right/top/bottom/grounded flags. It sits between the frame timing logic, the tile ROM, and the physics update that consumes the flags.

## Interface

**Parameters**
- TILE_SHIFT, 4: tile size is 2^TILE_SHIFT pixels square.
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.

**Ports**
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse that starts a probe pass.
- p0_x, p0_y, p1_x, p1_y  in  10 each  character top-left position in pixels.
- p0_w, p0_h, p1_w, p1_h  in  10 each  character width/height in pixels, each ≥ 3.
- tile_x  out  7  tile-ROM column address.
- tile_y  out  7  tile-ROM row address.
- tile_data  in  6  ROM data, valid the cycle after the address. Nonzero means solid.
- p0_coll  out  4  {left, right, top, bottom}.
- p1_coll  out  4  same encoding.
- p0_grounded, p1_grounded  out  1  equals the bottom bit.
- result_valid  out  1  one-cycle pulse when new flags are visible.
- busy  out  1  high from the cycle after frame_start is accepted through the DONE cycle.
- overrun  out  1  sticky flag; set by a frame_start that arrives while busy.

## Operation

- **States:** IDLE → PROBE → DRAIN → DONE → IDLE.
- **IDLE, frame_start=1:**
  - Latch all 12 geometry inputs.
  - Clear the probe counter (4 bits) and the scratch flags.
  - Go to PROBE.
- **PROBE:**
  - Probe index k runs 0..15: k[3] selects the player, k[2:0] selects the probe.
  - One address is issued per cycle.
  - Leave PROBE after k=15.
- **Probe points** (x, y, w, h are the latched values; arithmetic is 11-bit signed):
  - 0,1 left: (x−1, y+1) and (x−1, y+h−2).
  - 2,3 right: (x+w, y+1) and (x+w, y+h−2).
  - 4,5 top: (x+1, y−1) and (x+w−2, y−1).
  - 6,7 bottom: (x+1, y+h) and (x+w−2, y+h).
- **Address generation:**
  - tile_x = px >> TILE_SHIFT, tile_y = py >> TILE_SHIFT, truncated to 7 bits.
  - A probe is out-of-bounds (OOB) when px<0, px≥SCREEN_W, py<0 or py≥SCREEN_H.
  - For an OOB probe, tile_x/tile_y are driven 0. Its result comes from the configuration rule, not from tile_data.
- **Accumulation:**
  - A one-stage pipeline register carries {valid, player, side, oob} alongside each address.
  - On the next cycle the matching scratch bit is ORed with the solid result.
- **DRAIN:** one cycle that absorbs the data for k=15.
- **DONE:**
  - Copy the scratch flags into p0_coll/p1_coll and the grounded outputs.
  - Pulse result_valid.
  - Go to IDLE.
- **Output stability:** outputs hold their values between passes and never show partial results.
- **frame_start outside IDLE:** ignored, and sets overrun. overrun clears only on reset.
- **Reset (including mid-pass):** returns to IDLE and discards the pass. All outputs go to 0.

## Timing

- **Pass timeline:** frame_start is sampled at edge E0. Address k is driven during cycles E0+1+k, k = 0..15.
- **tile_data use:** sampled at the edge ending cycle E0+2+k.
- **DRAIN:** cycle E0+17.
- **DONE:** cycle E0+18; result_valid=1 in that cycle only. New flags are visible from E0+18.
- **busy:** high in cycles E0+1 through E0+18.
- **Back-to-back passes:** the earliest accepted following frame_start is in cycle E0+19.
- **Address registers:** tile_x/tile_y are registered outputs and read 0 in IDLE.
- **Reset values:** tile_x=0, tile_y=0, p0_coll=p1_coll=0, grounded=0, result_valid=0, busy=0, overrun=0.
- **Simultaneous events:** frame_start in the DONE cycle is ignored and sets overrun.

## Configuration

- **COLL_SCHED_EDGE_SOLID_EN defined:** an OOB probe counts as solid, so screen borders act as walls and floor.
- **COLL_SCHED_EDGE_SOLID_EN undefined:** an OOB probe counts as empty, so characters may leave the screen.
- **Unaffected either way:** the ROM access count and the cycle timing.

## Test plan

- **Open air:** P0 at (100,100) with w=h=32, ROM all zero; pulse frame_start. Expect result_valid exactly 18 cycles later, p0_coll=0000, and tile addresses (6,6),(6,8),(8,6)… in order.
- **Ground only:** ROM row 9 solid, P0 at (100,112) with h=32 (bottom probe y=144 → row 9). Expect p0_coll=0001 and p0_grounded=1; P1 unaffected.
- **Left edge OOB:** P1 at x=0, ROM empty. With COLL_SCHED_EDGE_SOLID_EN expect p1_coll=1000; without it expect 0000, and tile_x=0 on probes 8,9.
- **Overrun:** frame_start at E0 and again at E0+5. Expect overrun=1, a single result_valid at E0+18, and a next pass accepted at E0+19.
- **Reset mid-pass:** assert reset_n low at E0+7 for 2 cycles. Expect all outputs 0, IDLE state, and no result_valid. A new frame_start then completes normally.

Source files
------------

// File: rtl/collision_scheduler.sv
// collision_scheduler: walks 8 probe points around each fighter once per frame and folds tile-ROM hits into flags.
// Optional feature macro COLL_SCHED_EDGE_SOLID_EN: off-screen probes count as solid (screen edges act as walls).
module collision_scheduler #(
    parameter int TILE_SHIFT = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [9:0] p0_x,
    input  logic [9:0] p0_y,
    input  logic [9:0] p0_w,
    input  logic [9:0] p0_h,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p1_w,
    input  logic [9:0] p1_h,
    output logic [6:0] tile_x,
    output logic [6:0] tile_y,
    input  logic [5:0] tile_data,
    output logic [3:0] p0_coll,
    output logic [3:0] p1_coll,
    output logic       p0_grounded,
    output logic       p1_grounded,
    output logic       result_valid,
    output logic       busy,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    // Handshake: frame_start is accepted only in IDLE; anything else sets the sticky
    // overrun flag. result_valid is a one-cycle pulse with the flags already stable.
    typedef enum logic [1:0] {ST_IDLE, ST_PROBE, ST_DRAIN, ST_DONE} state_t;

`ifdef COLL_SCHED_EDGE_SOLID_EN
    localparam logic EDGE_SOLID = 1'b1;
`else
    localparam logic EDGE_SOLID = 1'b0;
`endif
    localparam logic signed [10:0] SCR_W = 11'(SCREEN_W);
    localparam logic signed [10:0] SCR_H = 11'(SCREEN_H);

    state_t            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [1:0][9:0]   gx_q, gx_d, gy_q, gy_d, gw_q, gw_d, gh_q, gh_d;
    logic [6:0]        tx_q, tx_d, ty_q, ty_d;
    logic [4:0]        m1_q, m1_d, m2_q, m2_d;   // {valid, player, side[1:0], oob}
    logic [1:0][3:0]   scratch_q, scratch_d;
    logic [3:0]        p0c_q, p0c_d, p1c_q, p1c_d;
    logic              rv_q, rv_d, ovr_q, ovr_d;

    logic [3:0]        nk;
    logic [9:0]        sx, sy, sw, sh;
    logic signed [10:0] ex, ey, ew, eh, px, py;
    logic              oob, solid, issue;
    logic [6:0]        tx_n, ty_n;

    // Geometry for the next probe: raw inputs when starting a pass, latched copy otherwise.
    always_comb begin
        nk = (state_q == ST_IDLE) ? 4'd0 : k_q + 4'd1;
        if (state_q == ST_IDLE) begin
            sx = p0_x;
            sy = p0_y;
            sw = p0_w;
            sh = p0_h;
        end else begin
            sx = gx_q[nk[3]];
            sy = gy_q[nk[3]];
            sw = gw_q[nk[3]];
            sh = gh_q[nk[3]];
        end
        ex = {1'b0, sx};
        ey = {1'b0, sy};
        ew = {1'b0, sw};
        eh = {1'b0, sh};
        case (nk[2:0])
            3'd0:    begin px = ex - 11'sd1;      py = ey + 11'sd1;      end
            3'd1:    begin px = ex - 11'sd1;      py = ey + eh - 11'sd2; end
            3'd2:    begin px = ex + ew;          py = ey + 11'sd1;      end
            3'd3:    begin px = ex + ew;          py = ey + eh - 11'sd2; end
            3'd4:    begin px = ex + 11'sd1;      py = ey - 11'sd1;      end
            3'd5:    begin px = ex + ew - 11'sd2; py = ey - 11'sd1;      end
            3'd6:    begin px = ex + 11'sd1;      py = ey + eh;          end
            default: begin px = ex + ew - 11'sd2; py = ey + eh;          end
        endcase
        oob  = px[10] | py[10] | (px >= SCR_W) | (py >= SCR_H);
        tx_n = 7'(px >> TILE_SHIFT);
        ty_n = 7'(py >> TILE_SHIFT);
    end

    assign solid = m2_q[0] ? EDGE_SOLID : (tile_data != 6'd0);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        gw_d      = gw_q;
        gh_d      = gh_q;
        tx_d      = '0;
        ty_d      = '0;
        m1_d      = '0;
        m2_d      = m1_q;
        scratch_d = scratch_q;
        p0c_d     = p0c_q;
        p1c_d     = p1c_q;
        rv_d      = 1'b0;
        ovr_d     = ovr_q | (frame_start & (state_q != ST_IDLE));
        issue     = 1'b0;

        // Side 0..3 (left,right,top,bottom) maps onto flag bit 3..0.
        if (m2_q[4] && solid) begin
            scratch_d[m2_q[3]][~m2_q[2:1]] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    gx_d      = {p1_x, p0_x};
                    gy_d      = {p1_y, p0_y};
                    gw_d      = {p1_w, p0_w};
                    gh_d      = {p1_h, p0_h};
                    k_d       = 4'd0;
                    scratch_d = '0;
                    issue     = 1'b1;
                    state_d   = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (k_q == 4'd15) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d   = k_q + 4'd1;
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                // scratch_d already holds the last probe's data, so DONE shows complete flags.
                p0c_d   = scratch_d[0];
                p1c_d   = scratch_d[1];
                rv_d    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            tx_d = oob ? 7'd0 : tx_n;
            ty_d = oob ? 7'd0 : ty_n;
            m1_d = {1'b1, nk[3], nk[2:1], oob};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            gw_q      <= '0;
            gh_q      <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            m1_q      <= '0;
            m2_q      <= '0;
            scratch_q <= '0;
            p0c_q     <= '0;
            p1c_q     <= '0;
            rv_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            gw_q      <= gw_d;
            gh_q      <= gh_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
            scratch_q <= scratch_d;
            p0c_q     <= p0c_d;
            p1c_q     <= p1c_d;
            rv_q      <= rv_d;
            ovr_q     <= ovr_d;
        end
    end

    assign tile_x       = tx_q;
    assign tile_y       = ty_q;
    assign p0_coll      = p0c_q;
    assign p1_coll      = p1c_q;
    assign p0_grounded  = p0c_q[0];
    assign p1_grounded  = p1c_q[0];
    assign result_valid = rv_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = ovr_q;
    assign state_dbg    = state_q;

endmodule
